// File: rtl/mul_div_ctrl.sv
// Multi-cycle multiply/divide unit for a pipelined core.
// One radix-2 step per cycle: shift-add for multiply and restoring
// shift-subtract for divide, both on operand magnitudes. Signs are
// applied to the result in the single FIX cycle that publishes it.
module mul_div_ctrl #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [DW-1:0] srcA,
  input  logic [DW-1:0] srcB,
  input  logic          cancel,
  output logic          stall_req,
  output logic          busy,
  output logic          done,
  output logic          we_hi,
  output logic          we_lo,
  output logic [DW-1:0] hi_out,
  output logic [DW-1:0] lo_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [1:0]    r_op;
  logic          r_signA;
  logic          r_signB;
  logic          r_dz;
  logic [5:0]    r_cnt;
  logic [DW-1:0] r_opnd;
  logic [DW-1:0] r_hi;
  logic [DW-1:0] r_lo;

  logic          w_accept;
  logic          w_divZero;
  logic          w_signA;
  logic          w_signB;
  logic [DW-1:0] w_magA;
  logic [DW-1:0] w_magB;

  logic [DW:0]     w_mulSum;
  logic [DW-1:0]   w_mulHi;
  logic [DW-1:0]   w_mulLo;
  logic [DW:0]     w_divShift;
  logic            w_divFits;
  logic [DW-1:0]   w_divHi;
  logic [DW-1:0]   w_divLo;
  logic [2*DW-1:0] w_prodNeg;
  logic            w_mulNeg;
  logic            w_quoNeg;
  logic [DW-1:0]   w_resHi;
  logic [DW-1:0]   w_resLo;

  // Acceptance and operand conditioning; only signed ops take magnitudes
  assign w_accept  = (r_state == IDLE) && start && !cancel;
  assign w_divZero = op[1] && (srcB == '0);
  assign w_signA   = op[0] & srcA[DW-1];
  assign w_signB   = op[0] & srcB[DW-1];
  assign w_magA    = w_signA ? -srcA : srcA;
  assign w_magB    = w_signB ? -srcB : srcB;

  // Multiply step: {carry,hi,lo} shifts right, multiplier bits leave lo[0]
  assign w_mulSum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
  assign w_mulHi  = w_mulSum[DW:1];
  assign w_mulLo  = {w_mulSum[0], r_lo[DW-1:1]};

  // Divide step: remainder takes the next dividend bit, subtract if it fits
  assign w_divShift = {r_hi, r_lo[DW-1]};
  assign w_divFits  = (w_divShift >= {1'b0, r_opnd});
  assign w_divHi    = w_divFits ? DW'(w_divShift - {1'b0, r_opnd}) : w_divShift[DW-1:0];
  assign w_divLo    = {r_lo[DW-2:0], w_divFits};

  // Sign fix-up of the magnitude result; divide-by-zero keeps the dividend
  assign w_prodNeg = -{r_hi, r_lo};
  assign w_mulNeg  = r_op[0] & (r_signA ^ r_signB);
  assign w_quoNeg  = r_op[0] & (r_signA ^ r_signB);

  // Select the published result for the current operation
  always_comb begin
    w_resHi = r_hi;
    w_resLo = r_lo;
    if (r_op[1]) begin
      w_resHi = r_signA ? -r_hi : r_hi;
      if (r_dz) begin
        w_resLo = '1;
      end else begin
        w_resLo = w_quoNeg ? -r_lo : r_lo;
      end
    end else if (w_mulNeg) begin
      w_resHi = w_prodNeg[2*DW-1:DW];
      w_resLo = w_prodNeg[DW-1:0];
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; cancel aborts ITER, FIX always lasts one cycle
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next = w_divZero ? FIX : ITER;
        end
      end
      ITER: begin
        if (cancel) begin
          w_next = IDLE;
        end else if (r_cnt == 6'(DW - 1)) begin
          w_next = FIX;
        end
      end
      FIX:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs: results and write enables are exposed only during FIX
  always_comb begin
    busy      = (r_state != IDLE);
    stall_req = (r_state == ITER) || (w_accept && rst);
    done      = 1'b0;
    we_hi     = 1'b0;
    we_lo     = 1'b0;
    hi_out    = '0;
    lo_out    = '0;
    if (r_state == FIX) begin
      done   = 1'b1;
      we_hi  = 1'b1;
      we_lo  = 1'b1;
      hi_out = w_resHi;
      lo_out = w_resLo;
    end
  end

  // Datapath: latch operands on accept, iterate one bit per ITER cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op    <= '0;
      r_signA <= 1'b0;
      r_signB <= 1'b0;
      r_dz    <= 1'b0;
      r_cnt   <= '0;
      r_opnd  <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op    <= op;
            r_signA <= w_signA;
            r_signB <= w_signB;
            r_dz    <= w_divZero;
            r_cnt   <= '0;
            if (op[1]) begin
              r_opnd <= w_magB;
              r_hi   <= w_divZero ? w_magA : '0;
              r_lo   <= w_magA;
            end else begin
              r_opnd <= w_magA;
              r_hi   <= '0;
              r_lo   <= w_magB;
            end
          end
        end
        ITER: begin
          r_cnt <= r_cnt + 6'd1;
          if (r_op[1]) begin
            r_hi <= w_divHi;
            r_lo <= w_divLo;
          end else begin
            r_hi <= w_mulHi;
            r_lo <= w_mulLo;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_ctrl.sv
// Self-checking bench for mul_div_ctrl: directed vector table, hand-written
// cancel/reset sequences and random operations against an arithmetic model.
module tb_mul_div_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        cancel;
  logic        stall_req;
  logic        busy;
  logic        done;
  logic        we_hi;
  logic        we_lo;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int testCount = 0;
  int failCount = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expHi;
    logic [31:0] expLo;
    bit          fixCancel;
    string       name;
  } vec_t;

  vec_t vecs[9];

  mul_div_ctrl #(.DW(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .srcA      (srcA),
    .srcB      (srcB),
    .cancel    (cancel),
    .stall_req (stall_req),
    .busy      (busy),
    .done      (done),
    .we_hi     (we_hi),
    .we_lo     (we_lo),
    .hi_out    (hi_out),
    .lo_out    (lo_out)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something blocks forever
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Reference: plain integer arithmetic of MULTU/MULT/DIVU/DIV
  function automatic logic [63:0] refModel(input logic [1:0] o, input logic [31:0] a,
                                           input logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'd0: res = {32'h0, a} * {32'h0, b};
      2'd1: begin
        q   = sa * sb;
        res = q;
      end
      2'd2: res = (b == 32'h0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
      default: begin
        if (b == 32'h0) begin
          res = {a, 32'hFFFFFFFF};
        end else begin
          q   = sa / sb;
          r   = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  task automatic applyStimulus(input logic st, input logic [1:0] o, input logic [31:0] a,
                               input logic [31:0] b, input logic c);
    start  = st;
    op     = o;
    srcA   = a;
    srcB   = b;
    cancel = c;
  endtask

  task automatic checkOutput(input string name, input logic [79:0] act, input logic [79:0] exp);
    testCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Issue one operation from IDLE and follow it to its FIX cycle
  task automatic runOp(input string name, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expHi,
                       input logic [31:0] expLo, input bit fixCancel, input bit releaseReset);
    int expLat;
    int badCycles;
    @(negedge clk);
    checkOutput({name, " idleBefore"}, 80'({busy, done, we_hi, we_lo}), 80'(0));
    applyStimulus(1'b1, o, a, b, 1'b0);
    if (releaseReset) rst = 1'b1;
    #1;
    checkOutput({name, " stallOnStart"}, 80'(stall_req), 80'(1));
    expLat    = (o[1] && b == 32'h0) ? 1 : 33;
    badCycles = 0;
    for (int k = 1; k <= expLat; k++) begin
      @(negedge clk);
      if (k < expLat) begin
        if ({busy, stall_req, done, we_hi, we_lo} != 5'b11000 || hi_out != 32'h0 ||
            lo_out != 32'h0) begin
          badCycles++;
        end
        applyStimulus(1'($urandom), 2'($urandom), $urandom, $urandom, 1'b0);
      end
    end
    checkOutput({name, " iterCycles"}, 80'(badCycles), 80'(0));
    checkOutput({name, " doneFlags"}, 80'({busy, stall_req, done, we_hi, we_lo}), 80'(5'b10111));
    checkOutput({name, " hi"}, 80'(hi_out), 80'(expHi));
    checkOutput({name, " lo"}, 80'(lo_out), 80'(expLo));
    applyStimulus(1'b0, 2'd0, 32'h0, 32'h0, fixCancel);
  endtask

  // Watch n cycles in which nothing may be busy or written
  task automatic watchQuiet(input string name, input int n);
    int hits;
    hits = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (busy || done || we_hi || we_lo) hits++;
    end
    checkOutput(name, 80'(hits), 80'(0));
  endtask

  initial begin
    logic [63:0] exp;
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    int          sel;

    vecs[0] = '{2'd1, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, "multNeg"};
    vecs[1] = '{2'd0, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 1'b0, "multu"};
    vecs[2] = '{2'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, "divNeg"};
    vecs[3] = '{2'd2, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, "divu100by7"};
    vecs[4] = '{2'd2, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b0, "divuByZero"};
    vecs[5] = '{2'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, "divMinByM1"};
    vecs[6] = '{2'd3, 32'h80000000, 32'h00000000, 32'h80000000, 32'hFFFFFFFF, 1'b1, "divByZeroFixCancel"};
    vecs[7] = '{2'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, "multMinMin"};
    vecs[8] = '{2'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b1, "divPosByNegFixCancel"};

    // Reset state, with start high to show stall_req is masked
    rst = 1'b0;
    applyStimulus(1'b1, 2'd1, 32'h5, 32'h3, 1'b0);
    #3;
    checkOutput("resetOutputs", 80'({busy, done, we_hi, we_lo, stall_req, hi_out, lo_out}), 80'(0));
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Directed vector table, issued back-to-back
    for (int i = 0; i < 9; i++) begin
      runOp(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].expHi, vecs[i].expLo,
            vecs[i].fixCancel, 1'b0);
    end

    // Cancel ten cycles into ITER, then a normal operation
    @(negedge clk);
    applyStimulus(1'b1, 2'd0, 32'h12345678, 32'h9ABCDEF0, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    checkOutput("cancelToIdle", 80'({busy, done, we_hi, we_lo}), 80'(0));
    watchQuiet("cancelNoWrite", 30);
    runOp("afterCancel", 2'd2, 32'd1000, 32'd33, 32'd10, 32'd30, 1'b0, 1'b0);

    // start and cancel together in IDLE: cancel wins
    @(negedge clk);
    applyStimulus(1'b1, 2'd1, 32'h7, 32'h7, 1'b1);
    #1;
    checkOutput("startCancelStall", 80'(stall_req), 80'(0));
    @(negedge clk);
    checkOutput("startCancelBusy", 80'(busy), 80'(0));
    applyStimulus(1'b0, 2'd0, 32'h0, 32'h0, 1'b0);

    // Asynchronous reset between edges in the middle of ITER
    @(negedge clk);
    applyStimulus(1'b1, 2'd3, 32'hDEADBEEF, 32'h00000123, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2;
    rst   = 1'b0;
    start = 1'b1;
    #1;
    checkOutput("asyncResetOutputs",
                80'({busy, done, we_hi, we_lo, stall_req, hi_out, lo_out}), 80'(0));
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    watchQuiet("resetDiscards", 40);

    // Start already present as reset releases is taken at the first edge
    @(negedge clk);
    #2;
    rst = 1'b0;
    runOp("startAtRelease", 2'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000,
          1'b0, 1'b1);

    // Random operations against the arithmetic model
    for (int i = 0; i < 30; i++) begin
      ro  = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) rb = 32'h0;
      if (sel == 1) ra = 32'h80000000;
      if (sel == 2) rb = $urandom_range(1, 15);
      if (sel == 3) rb = 32'hFFFFFFFF;
      exp = refModel(ro, ra, rb);
      runOp("rand", ro, ra, rb, exp[63:32], exp[31:0], (i % 5) == 0, 1'b0);
    end

    @(negedge clk);
    checkOutput("finalIdle", 80'({busy, done, we_hi, we_lo, stall_req}), 80'(0));

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
